cpu_attack_fsm: RTL

Consumes the 2-bit random CPU attack type (STANDBY=00, LIGHT=01, HEAVY=10) from the CPU type generator. It turns each non-standby decision into a timed attack sequence: windup, strike, then recovery. On the strike it emits a one-cycle hit strobe with a damage value, which goes to the health/score logic downstream. All timing is counted in game ticks (`i_tick` enable pulses), not clocks.

---
 rtl/cpu_attack_fsm.sv | 138 +++++++++++++
 1 files changed

// File: rtl/cpu_attack_fsm.sv
// CPU attack sequencer: turns a sampled attack type into windup, strike and
// recovery phases timed in game ticks, with a one-clock hit strobe at strike entry.
module cpu_attack_fsm #(
  parameter int LIGHT_WINDUP = 4,
  parameter int HEAVY_WINDUP = 10,
  parameter int LIGHT_ACTIVE = 2,
  parameter int HEAVY_ACTIVE = 3,
  parameter int RECOVER      = 6,
  parameter int LIGHT_DMG    = 2,
  parameter int HEAVY_DMG    = 5,
  parameter int CNT_W        = 5
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_tick,
  input  logic       i_enable,
  input  logic [1:0] i_cpu_type,
  input  logic       i_player_block,
  output logic [1:0] o_state,
  output logic       o_telegraph,
  output logic       o_attack_active,
  output logic       o_hit_strobe,
  output logic [3:0] o_damage,
  output logic       o_heavy,
  output logic [7:0] o_hit_count
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_WINDUP  = 2'b01,
    S_STRIKE  = 2'b10,
    S_RECOVER = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] L_WIND = CNT_W'(LIGHT_WINDUP);
  localparam logic [CNT_W-1:0] H_WIND = CNT_W'(HEAVY_WINDUP);
  localparam logic [CNT_W-1:0] L_ACT  = CNT_W'(LIGHT_ACTIVE);
  localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(HEAVY_ACTIVE);
  localparam logic [CNT_W-1:0] REC    = CNT_W'(RECOVER);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
  localparam logic [3:0]       L_DMG  = 4'(LIGHT_DMG);
  localparam logic [3:0]       H_DMG  = 4'(HEAVY_DMG);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             heavy_reg, heavy_next;
  logic             strobe_reg, strobe_next;
  logic [3:0]       damage_reg, damage_next;
  logic [7:0]       count_reg, count_next;
  logic [3:0]       base_dmg;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      heavy_reg  <= 1'b0;
      strobe_reg <= 1'b0;
      damage_reg <= '0;
      count_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      heavy_reg  <= heavy_next;
      strobe_reg <= strobe_next;
      damage_reg <= damage_next;
      count_reg  <= count_next;
    end
  end

  assign base_dmg = heavy_reg ? H_DMG : L_DMG;

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    heavy_next  = heavy_reg;
    strobe_next = 1'b0;
    damage_next = '0;
    count_next  = count_reg;
    // Abort wins over everything, including a coincident strike entry
    if (!i_enable) begin
      state_next = S_IDLE;
      cnt_next   = '0;
      heavy_next = 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (i_tick && (i_cpu_type == 2'b01 || i_cpu_type == 2'b10)) begin
            heavy_next = i_cpu_type[1];
            cnt_next   = i_cpu_type[1] ? H_WIND : L_WIND;
            state_next = S_WINDUP;
          end
        end
        S_WINDUP: begin
          if (i_tick) begin
            if (cnt_reg == ONE) begin
              state_next  = S_STRIKE;
              cnt_next    = heavy_reg ? H_ACT : L_ACT;
              strobe_next = 1'b1;
              damage_next = i_player_block ? (base_dmg >> 1) : base_dmg;
              if (count_reg != 8'hFF) count_next = count_reg + 8'd1;
            end else begin
              cnt_next = cnt_reg - ONE;
            end
          end
        end
        S_STRIKE: begin
          if (i_tick) begin
            if (cnt_reg == ONE) begin
              state_next = S_RECOVER;
              cnt_next   = REC;
            end else begin
              cnt_next = cnt_reg - ONE;
            end
          end
        end
        default: begin
          if (i_tick) begin
            if (cnt_reg == ONE) begin
              state_next = S_IDLE;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg - ONE;
            end
          end
        end
      endcase
    end
  end

  assign o_state         = state_reg;
  assign o_telegraph     = (state_reg == S_WINDUP);
  assign o_attack_active = (state_reg == S_STRIKE);
  assign o_hit_strobe    = strobe_reg;
  assign o_damage        = damage_reg;
  assign o_heavy         = heavy_reg;
  assign o_hit_count     = count_reg;

endmodule
